// File: rtl/mvb_modport.sv
// mvb_modport: registered MVB pipeline stage with a 2-entry skid buffer that drops words carrying no valid item
module mvb_modport #(
  parameter int ITEMS      = 4,
  parameter int ITEM_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [ITEMS*ITEM_WIDTH-1:0] RX_DATA,
  input  logic [ITEMS-1:0]            RX_VLD,
  input  logic                        RX_SRC_RDY,
  output logic                        RX_DST_RDY,
  output logic [ITEMS*ITEM_WIDTH-1:0] TX_DATA,
  output logic [ITEMS-1:0]            TX_VLD,
  output logic                        TX_SRC_RDY,
  input  logic                        TX_DST_RDY
);
  localparam int WORD_WIDTH = ITEMS * ITEM_WIDTH;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t                state, state_nx;
  logic [WORD_WIDTH-1:0] main_data, skid_data;
  logic [ITEMS-1:0]      main_vld, skid_vld;
  logic                  rdy, load, pop, main_rx, main_skid, skid_rx;
  always_comb begin
    load      = RX_SRC_RDY & rdy & (|RX_VLD);
    pop       = (state != EMPTY) & TX_DST_RDY;
    state_nx  = state;
    main_rx   = 1'b0;
    main_skid = 1'b0;
    skid_rx   = 1'b0;
    unique case (state)
      EMPTY: begin
        main_rx  = load;
        state_nx = load ? ONE : EMPTY;
      end
      ONE: begin
        main_rx  = load & pop;
        skid_rx  = load & ~pop;
        state_nx = load ? (pop ? ONE : FULL) : (pop ? EMPTY : ONE);
      end
      FULL: begin
        main_skid = pop;
        state_nx  = pop ? ONE : FULL;
      end
      default: state_nx = EMPTY;
    endcase
  end
  // ready is registered from the next state so it never sees TX_DST_RDY combinationally
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= EMPTY;
      rdy       <= 1'b0;
      main_data <= '0;
      main_vld  <= '0;
      skid_data <= '0;
      skid_vld  <= '0;
    end else begin
      state <= state_nx;
      rdy   <= state_nx != FULL;
      if (main_rx) begin
        main_data <= RX_DATA;
        main_vld  <= RX_VLD;
      end else if (main_skid) begin
        main_data <= skid_data;
        main_vld  <= skid_vld;
      end
      if (skid_rx) begin
        skid_data <= RX_DATA;
        skid_vld  <= RX_VLD;
      end
    end
  end
  assign RX_DST_RDY = rdy;
  assign TX_SRC_RDY = state != EMPTY;
  assign TX_DATA    = main_data;
  assign TX_VLD     = main_vld & {ITEMS{TX_SRC_RDY}};
  param_ok: assert property (@(posedge CLK) ITEMS > 0 && ITEM_WIDTH > 0);
endmodule

// File: tb/tb_mvb_modport.sv
// tb_mvb_modport: randomized scoreboard bench for mvb_modport, default and 1x1-bit configurations
module tb_mvb_modport;
  logic        clk = 0;
  logic        RESET = 0;
  logic [31:0] RX_DATA = '0;
  logic [3:0]  RX_VLD = '0;
  logic        RX_SRC_RDY = 0;
  logic        RX_DST_RDY;
  logic [31:0] TX_DATA;
  logic [3:0]  TX_VLD;
  logic        TX_SRC_RDY;
  logic        TX_DST_RDY = 1;
  logic        s_rst = 0, s_rx_data = 0, s_rx_vld = 0, s_rx_src = 0, s_rx_dst;
  logic        s_tx_data, s_tx_vld, s_tx_src, s_tx_dst = 1;
  int          compared = 0, mismatched = 0;
  bit          rand_tx = 0, s_done = 0;

  always #5 clk = ~clk;

  mvb_modport dut (
    .CLK(clk), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_VLD(RX_VLD), .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
    .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
  );

  mvb_modport #(.ITEMS(1), .ITEM_WIDTH(1)) dut_s (
    .CLK(clk), .RESET(s_rst),
    .RX_DATA(s_rx_data), .RX_VLD(s_rx_vld), .RX_SRC_RDY(s_rx_src), .RX_DST_RDY(s_rx_dst),
    .TX_DATA(s_tx_data), .TX_VLD(s_tx_vld), .TX_SRC_RDY(s_tx_src), .TX_DST_RDY(s_tx_dst)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stage holds a FIFO of non-empty accepted words, at most two of them
  logic [35:0] q[$];
  bit          held_ok = 0, hold_exp = 0;
  logic [31:0] last_d;
  logic [3:0]  last_v;
  always @(negedge clk) begin
    int n;
    bit pop, load;
    n = q.size();
    chk("tx_src_rdy", TX_SRC_RDY, n > 0);
    chk("rx_dst_rdy", RX_DST_RDY, held_ok && n < 2);
    if (!held_ok) chk("reset_tx_data", TX_DATA, 0);
    if (n == 0) chk("idle_tx_vld", TX_VLD, 0);
    if (hold_exp) chk("hold_tx_data", TX_DATA, last_d);
    if (hold_exp && n > 0) chk("stall_tx_vld", TX_VLD, last_v);
    pop  = n > 0 && TX_DST_RDY;
    load = held_ok && n < 2 && RX_SRC_RDY && RX_VLD != 0;
    if (!RESET) begin
      q.delete();
      held_ok  = 0;
      hold_exp = 0;
    end else begin
      if (pop) begin
        chk("tx_word", {TX_VLD, TX_DATA}, q[0]);
        void'(q.pop_front());
      end
      if (load) q.push_back({RX_VLD, RX_DATA});
      held_ok  = 1;
      hold_exp = n > 0 ? (!pop || q.size() == 0) : q.size() == 0;
    end
    last_d = TX_DATA;
    last_v = TX_VLD;
  end

  logic [1:0] sq[$];
  bit         s_ok = 0;
  always @(negedge clk) begin
    int n;
    n = sq.size();
    chk("s_tx_src_rdy", s_tx_src, n > 0);
    chk("s_rx_dst_rdy", s_rx_dst, s_ok && n < 2);
    if (n == 0) chk("s_idle_tx_vld", s_tx_vld, 0);
    if (!s_rst) begin
      sq.delete();
      s_ok = 0;
    end else begin
      if (n > 0 && s_tx_dst) begin
        chk("s_tx_word", {s_tx_vld, s_tx_data}, sq[0]);
        void'(sq.pop_front());
      end
      if (s_ok && n < 2 && s_rx_src && s_rx_vld) sq.push_back({s_rx_vld, s_rx_data});
      s_ok = 1;
    end
  end

  always @(posedge clk) if (rand_tx) begin
    #1 TX_DST_RDY = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [31:0] d, input logic [3:0] v);
    int g = 0;
    bit acc = 0;
    RX_DATA = d;
    RX_VLD = v;
    RX_SRC_RDY = 1;
    do begin
      @(negedge clk);
      acc = RX_DST_RDY === 1'b1;
      @(posedge clk);
      #1 g++;
    end while (!acc && g < 100);
    if (!acc) chk("send_timeout", 0, 1);
    RX_SRC_RDY = 0;
  endtask

  task automatic drain();
    int g = 0;
    rand_tx = 0;
    @(posedge clk);
    #1 TX_DST_RDY = 1;
    while (q.size() != 0 && g < 200) begin
      @(posedge clk);
      #1 g++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (200) begin
      @(posedge clk);
      #1;
      s_rst     = 1;
      s_rx_src  = 1'($urandom_range(0, 1));
      s_rx_data = 1'($urandom_range(0, 1));
      s_rx_vld  = 1'($urandom_range(0, 1));
      s_tx_dst  = 1'($urandom_range(0, 1));
    end
    s_rx_src = 0;
    s_tx_dst = 1;
    repeat (5) @(posedge clk);
    s_done = 1;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 RESET = 1;
    repeat (2) @(posedge clk);
    #1;
    send(32'h04030201, 4'b1111);
    send(32'h08070605, 4'b0101);
    drain();
    send(32'h000000a1, 4'b0001);
    send(32'h000000b2, 4'b0000);
    send(32'hc3000000, 4'b1000);
    drain();
    TX_DST_RDY = 0;
    fork
      begin
        send(32'h11111111, 4'b0011);
        send(32'h22222222, 4'b1100);
        send(32'h33333333, 4'b1111);
      end
      begin
        repeat (6) @(posedge clk);
        #1 TX_DST_RDY = 1;
      end
    join
    drain();
    rand_tx = 1;
    repeat (1000) begin
      send($urandom, ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    TX_DST_RDY = 0;
    send(32'hdeadbeef, 4'b1111);
    send(32'hcafef00d, 4'b0110);
    RESET = 0;
    RX_DATA = 32'h55555555;
    RX_VLD = 4'b1111;
    RX_SRC_RDY = 1;
    @(posedge clk);
    #1;
    RESET = 1;
    RX_SRC_RDY = 0;
    repeat (3) @(posedge clk);
    #1 TX_DST_RDY = 1;
    send(32'h0badf00d, 4'b1001);
    drain();
    wait (s_done);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mvb_modport.md
Name: mvb_modport

Overview:
- Registered pipeline stage for the Multi-Value Bus (MVB): one RX port (data into the block) and one TX port (data out of the block).
- Breaks all combinational paths between the two ports, including the ready path, using a 2-entry skid buffer.
- Sits between any MVB producer and consumer.
- Sustains full throughput of one word per cycle, preserves word order, and discards words that carry no valid item.

Parameters:
ITEMS, 4, number of item slots per MVB word; must be > 0.
ITEM_WIDTH, 8, bit width of one item; must be > 0.
(derived) WORD_WIDTH = ITEMS*ITEM_WIDTH.

Ports:
CLK  in  1  clock; everything is sampled on the rising edge.
RESET  in  1  synchronous, active-low reset (0 = reset asserted).
RX_DATA  in  WORD_WIDTH  input word; item i is bits [i*ITEM_WIDTH +: ITEM_WIDTH].
RX_VLD  in  ITEMS  per-item valid flags.
RX_SRC_RDY  in  1  input word present.
RX_DST_RDY  out  1  block can accept a word; driven from a register.
TX_DATA  out  WORD_WIDTH  output word.
TX_VLD  out  ITEMS  output per-item valid flags.
TX_SRC_RDY  out  1  output word present.
TX_DST_RDY  in  1  downstream accepts the word.

Behaviour:
- Transfer rule (both ports): a word moves on a rising edge where SRC_RDY=1 and DST_RDY=1 on the same cycle.
- Empty-word drop: an RX word accepted with RX_VLD=0 (all zeros) is consumed and never appears on TX.
- Pass-through: any RX word with at least one VLD bit set is reproduced on TX exactly, DATA and VLD bit-for-bit, with no item reordering or compaction.
- Storage: two word registers, a main (output) register and a skid register.
- State encoding, by number of words held:
  - EMPTY: TX_SRC_RDY=0, RX_DST_RDY=1.
  - ONE: TX_SRC_RDY=1, RX_DST_RDY=1.
  - FULL: TX_SRC_RDY=1, RX_DST_RDY=0.
- Let load = RX accept with |RX_VLD, and pop = TX_SRC_RDY & TX_DST_RDY.
  - EMPTY: load -> ONE (word enters the main register).
  - ONE: load and pop together -> ONE (main register takes the new word). Load only -> FULL (new word goes to skid). Pop only -> EMPTY.
  - FULL: pop -> ONE (skid moves to main). No RX accept is possible in FULL.
- Latency: a word accepted at edge N is on TX from cycle N+1, assuming no older word is pending.
- Throughput: one word per cycle when TX_DST_RDY is held at 1.
- Stall: while TX_SRC_RDY=1 and TX_DST_RDY=0, TX_DATA and TX_VLD hold stable.
- Invalid output: when TX_SRC_RDY=0, TX_VLD is forced to 0 and TX_DATA holds its last value.
- RX_DST_RDY does not depend combinationally on TX_DST_RDY. It depends on registered state only.
- Reset (RESET=0 at a rising edge):
  - Results: state EMPTY, TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, RX_DST_RDY=0.
  - Scope: the reset applies even mid-transfer; any buffered words are lost.
  - Release: RX_DST_RDY rises to 1 on the first edge with RESET=1.
- Inputs are sampled only when RX_DST_RDY=1. While RX_DST_RDY=0, RX changes are ignored.
- Formal parameter check: assertion that ITEMS>0 and ITEM_WIDTH>0.

Test Plan:
- Streaming (ITEMS=4, ITEM_WIDTH=8): RX words 0x04030201/VLD=1111, then 0x08070605/VLD=0101 on consecutive cycles, TX_DST_RDY=1 -> the same two words appear on TX one cycle later, back-to-back; RX_DST_RDY stays 1.
- Empty drop: RX sequence A (VLD=0001), B (VLD=0000), C (VLD=1000) -> TX shows only A then C; TX_SRC_RDY is 1 for exactly 2 cycles.
- Backpressure: TX_DST_RDY=0 while streaming 3 words -> TX holds word 1 stable; RX_DST_RDY drops to 0 after 2 words are accepted. Release TX_DST_RDY -> words 1, 2, 3 come out in order, with no loss or duplication.
- Simultaneous load/pop in ONE with random TX_DST_RDY (50%) over 1000 random words -> TX sequence equals the RX sequence minus empty words; the protocol checker raises no violations.
- Reset mid-operation: FULL state, then RESET=0 for 1 cycle -> TX_SRC_RDY=0, TX_VLD=0, RX_DST_RDY=0 during reset. RX_DST_RDY=1 on the next cycle, and no stale word is emitted.
- Corner parameters ITEMS=1, ITEM_WIDTH=1: a single-bit word stream -> correct pass-through and correct empty-drop.
